sign_narrow: RTL
================

// Module: sign_narrow
// PURPOSE
//   Narrows signed IN_W-bit words to OUT_W bits; the inverse of the sign-extension path.
//   Flags every word whose value does not fit in OUT_W bits and counts those words.
//   Valid/ready streaming with a 2-entry output buffer; sits between the 32-bit datapath and 16-bit consumers.
// PARAMETERS
//   IN_W    32  input word width (signed, two's complement)
//   OUT_W   16  output word width; must satisfy 1 < OUT_W < IN_W
//   CNT_W    8  width of the overflow event counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      block can accept a word this cycle
//   in_data    in   IN_W   signed input word
//   out_valid  out  1      output word valid
//   out_ready  in   1      consumer accepts the output word
//   out_data   out  OUT_W  narrowed word
//   out_ovf    out  1      out_data's source did not fit in OUT_W bits
//   ovf_clr    in   1      synchronous clear of ovf_count
//   ovf_count  out  CNT_W  saturating count of accepted overflowing words
// BEHAVIOUR
//   - Reset (rst_n=0, async): buffer empty, out_valid=0, out_data=0, out_ovf=0, ovf_count=0. in_ready=0 while rst_n=0.
//   - Handshakes: push when in_valid&in_ready; pop when out_valid&out_ready. in_data is sampled only on a push.
//     in_valid may drop without a push.
//   - Overflow: ovf = in_data[IN_W-1:OUT_W-1] not all-equal, i.e. the value is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - Narrowing: out_data = in_data[OUT_W-1:0] (see CONFIGURATION for saturation). out_ovf travels with the word.
//   - Buffer FSM, states EMPTY/ONE/FULL (2-entry FIFO, registered outputs):
//       EMPTY: push -> ONE
//       ONE:   push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE (new word becomes head)
//       FULL:  pop -> ONE; no push accepted
//   - in_ready = (state != FULL) & rst_n. It is registered-state based and has no comb path from out_ready.
//   - out_valid = (state != EMPTY). Head word and out_ovf hold stable while out_valid&!out_ready.
//   - Latency: word pushed in cycle N is on out_data with out_valid=1 in cycle N+1 if the buffer was empty.
//   - Throughput: 1 word/cycle sustained when out_ready=1. Order is strictly preserved.
//   - ovf_count: +1 on each push with ovf=1, counted at acceptance, not at output.
//     Saturates at 2^CNT_W-1, no wrap.
//     ovf_clr has priority: a clear and an overflowing push in the same cycle -> ovf_count=0.
//   - Reset mid-operation: buffered words are discarded, no partial output, all outputs return to reset values.
// CONFIGURATION
//   SIGN_NARROW_SAT_EN defined: overflowing words are clamped.
//     Positive -> 2^(OUT_W-1)-1 (16'h7FFF); negative -> -2^(OUT_W-1) (16'h8000). out_ovf is still 1.
//   SIGN_NARROW_SAT_EN undefined: overflowing words are truncated to the low OUT_W bits (wrap). out_ovf is still 1.
//   Handshake, latency and counter behaviour are identical in both builds.
// TESTING
//   1 In-range: push 32'hFFFF8000, then 32'h00007FFF, out_ready=1
//     -> out_data 16'h8000, then 16'h7FFF; out_ovf=0; ovf_count=0; each appears 1 cycle after push.
//   2 Overflow: push 32'h00012345 and 32'hFFFE0000
//     -> out_ovf=1 both; SAT build: 16'h7FFF, 16'h8000; wrap build: 16'h2345, 16'h0000; ovf_count=2.
//   3 Backpressure: out_ready=0, push 3 words
//     -> 2 accepted, in_ready=0 after the 2nd, 3rd held.
//     Raise out_ready -> words emerge in order, in_ready returns 1 the cycle after the first pop.
//   4 Streaming: in_valid=1, out_ready=1 for 100 cycles of incrementing data
//     -> 100 outputs, 1/cycle, in order, no gaps after the first.
//   5 Counter: 300 overflowing pushes with CNT_W=8 -> ovf_count=255.
//     ovf_clr asserted with an overflowing push -> ovf_count=0.
//   6 Reset: assert rst_n=0 while FULL
//     -> out_valid=0, ovf_count=0 immediately (async); after release the buffer is empty and in_ready=1.

Source files
------------

// File: rtl/sign_narrow.sv
// sign_narrow: signed IN_W -> OUT_W narrowing stage with a 2-entry output buffer.
// Define SIGN_NARROW_SAT_EN to clamp out-of-range words instead of wrapping them.
module sign_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [OUT_W-1:0] data;
    } word_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t           state;
    state_t           state_nx;
    word_t            head;
    word_t            tail;
    word_t            word_in;
    logic [IN_W-OUT_W:0] top;
    logic             in_ovf;
    logic             push;
    logic             pop;
    logic             load_head;
    logic             head_from_tail;
    logic             load_tail;
    logic [CNT_W-1:0] cnt;

    // A word fits when every bit from the OUT_W sign position up is a copy of the sign.
    assign top    = in_data[IN_W-1:OUT_W-1];
    assign in_ovf = ~((&top) | ~(|top));

    always_comb begin
        word_in.ovf  = in_ovf;
        word_in.data = in_data[OUT_W-1:0];
`ifdef SIGN_NARROW_SAT_EN
        if (in_ovf) begin
            word_in.data = in_data[IN_W-1] ? NEG_MIN : POS_MAX;
        end
`endif
    end

    assign in_ready  = (state != FULL) & rst_n;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (push) state_nx = ONE;
            end
            ONE: begin
                unique case (1'b1)
                    push & ~pop: state_nx = FULL;
                    pop & ~push: state_nx = EMPTY;
                    default:     state_nx = ONE;
                endcase
            end
            FULL: begin
                if (pop) state_nx = ONE;
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        unique case (state)
            EMPTY: load_head = push;
            ONE: begin
                load_head = push & pop;
                load_tail = push & ~pop;
            end
            FULL: begin
                load_head      = pop;
                head_from_tail = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head) begin
                head <= head_from_tail ? tail : word_in;
            end
            if (load_tail) begin
                tail <= word_in;
            end
        end
    end

    // Clear wins over a same-cycle overflowing push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ovf_clr) begin
            cnt <= '0;
        end else if (push & in_ovf & (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign out_data  = head.data;
    assign out_ovf   = head.ovf;
    assign ovf_count = cnt;

endmodule
